// File: rtl/uart_rx_pack16_pkg.sv
// uart_rx_pack16_pkg: shared assembler state encoding and default inter-byte timeout
package uart_rx_pack16_pkg;
  typedef enum logic {S_LO, S_HI} pack_state_t;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;
endpackage

// File: rtl/uart_rx_pack16.sv
// uart_rx_pack16: packs low-then-high bytes into words; clk/rst(async low)/clear in, byte_valid/byte_in in, word_ready in, word_out/word_valid/busy/frame_err/overflow out
module uart_rx_pack16
  import uart_rx_pack16_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        word_ready,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        busy,
  output logic        frame_err,
  output logic        overflow
);
  pack_state_t state, state_n;
  logic [15:0] cnt;
  logic [7:0]  lo;
  logic        expire, done;
  always_comb begin
    expire  = state == S_HI && !byte_valid && cnt == TIMEOUT_CYCLES - 16'd1;
    done    = state == S_HI && byte_valid && !clear;
    state_n = clear ? S_LO : state == S_LO ? (byte_valid ? S_HI : S_LO) : (byte_valid || expire) ? S_LO : S_HI;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_LO;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 16'd0;
      lo         <= 8'h00;
      word_out   <= 16'h0000;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cnt       <= (state == S_HI && state_n == S_HI) ? cnt + 16'd1 : 16'd0;
      frame_err <= expire && !clear;
      if (clear) lo <= 8'h00;
      else if (state == S_LO && byte_valid) lo <= byte_in;
      if (clear) begin
        word_valid <= 1'b0;
        overflow   <= 1'b0;
      end else if (done) begin
        if (!word_valid || word_ready) begin
          word_out   <= {byte_in, lo};
          word_valid <= 1'b1;
        end else overflow <= 1'b1;
      end else if (word_ready) word_valid <= 1'b0;
    end
  end
  assign busy = state == S_HI;
endmodule

// File: tb/tb_uart_rx_pack16.sv
// tb_uart_rx_pack16: directed and randomized checks of uart_rx_pack16 against a timestamp-based reference model
module tb_uart_rx_pack16;
  localparam int T = 16;
  logic        clk = 1'b0, rst = 1'b0, clear = 1'b0, byte_valid = 1'b0, word_ready = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic [15:0] word_out;
  logic        word_valid, busy, frame_err, overflow;
  logic [19:0] st;
  int          nvec = 0, nerr = 0, cyc = 0, t_lo = 0;
  bit          m_have_lo, m_wv, m_ovf, m_ferr;
  logic [7:0]  m_lo;
  logic [15:0] m_word;
  uart_rx_pack16 #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .byte_valid(byte_valid), .byte_in(byte_in),
    .word_ready(word_ready), .word_out(word_out), .word_valid(word_valid), .busy(busy),
    .frame_err(frame_err), .overflow(overflow)
  );
  assign st = {word_out, word_valid, busy, frame_err, overflow};
  always #5 clk = ~clk;
  task automatic model_reset();
    m_have_lo = 0; m_wv = 0; m_ovf = 0; m_ferr = 0; m_word = 16'h0000; m_lo = 8'h00;
  endtask
  task automatic step(input logic bv, input logic [7:0] b, input logic rdy, input logic clr);
    bit complete;
    logic [15:0] w;
    complete = 0; w = 16'h0000;
    byte_valid = bv; byte_in = b; word_ready = rdy; clear = clr;
    @(posedge clk);
    cyc++;
    m_ferr = 0;
    if (clr) begin
      m_have_lo = 0; m_wv = 0; m_ovf = 0;
    end else begin
      if (m_have_lo && bv) begin complete = 1; w = {b, m_lo}; m_have_lo = 0; end
      else if (m_have_lo && cyc - t_lo == T) begin m_have_lo = 0; m_ferr = 1; end
      else if (!m_have_lo && bv) begin m_have_lo = 1; m_lo = b; t_lo = cyc; end
      if (complete && (!m_wv || rdy)) begin m_word = w; m_wv = 1; end
      else if (complete) m_ovf = 1;
      else if (rdy) m_wv = 0;
    end
    #1;
    byte_valid = 1'b0; clear = 1'b0;
  endtask
  task automatic test_reset();
    #3;
    nvec++; if (st !== 20'h0) begin nerr++; $display("FAIL reset_state got %h exp %h", st, 20'h0); end
    model_reset();
    @(negedge clk) rst = 1'b1;
  endtask
  task automatic test_basic();
    step(1, 8'h34, 1, 0);
    nvec++; if (st !== {16'h0000, 4'b0100}) begin nerr++; $display("FAIL basic_lo got %h exp %h", st, {16'h0000, 4'b0100}); end
    for (int i = 0; i < 2; i++) begin
      step(0, 8'h00, 1, 0);
      nvec++; if (st !== {16'h0000, 4'b0100}) begin nerr++; $display("FAIL basic_gap got %h exp %h", st, {16'h0000, 4'b0100}); end
    end
    step(1, 8'h12, 1, 0);
    nvec++; if (st !== {16'h1234, 4'b1000}) begin nerr++; $display("FAIL basic_word got %h exp %h", st, {16'h1234, 4'b1000}); end
    step(0, 8'h00, 1, 0);
    nvec++; if (st !== {16'h1234, 4'b0000}) begin nerr++; $display("FAIL basic_consume got %h exp %h", st, {16'h1234, 4'b0000}); end
  endtask
  task automatic test_timeout();
    step(1, 8'hAA, 1, 0);
    for (int i = 0; i < T - 1; i++) begin
      step(0, 8'h00, 1, 0);
      nvec++; if (st !== {16'h1234, 4'b0100}) begin nerr++; $display("FAIL tmo_wait%0d got %h exp %h", i, st, {16'h1234, 4'b0100}); end
    end
    step(0, 8'h00, 1, 0);
    nvec++; if (st !== {16'h1234, 4'b0010}) begin nerr++; $display("FAIL tmo_pulse got %h exp %h", st, {16'h1234, 4'b0010}); end
    step(0, 8'h00, 1, 0);
    nvec++; if (st !== {16'h1234, 4'b0000}) begin nerr++; $display("FAIL tmo_after got %h exp %h", st, {16'h1234, 4'b0000}); end
    step(1, 8'h01, 1, 0);
    step(1, 8'h02, 1, 0);
    nvec++; if (st !== {16'h0201, 4'b1000}) begin nerr++; $display("FAIL tmo_word got %h exp %h", st, {16'h0201, 4'b1000}); end
    step(0, 8'h00, 1, 0);
  endtask
  task automatic test_overflow();
    step(1, 8'h11, 0, 0);
    step(1, 8'h11, 0, 0);
    nvec++; if (st !== {16'h1111, 4'b1000}) begin nerr++; $display("FAIL ovf_first got %h exp %h", st, {16'h1111, 4'b1000}); end
    step(1, 8'h22, 0, 0);
    step(1, 8'h22, 0, 0);
    nvec++; if (st !== {16'h1111, 4'b1001}) begin nerr++; $display("FAIL ovf_drop got %h exp %h", st, {16'h1111, 4'b1001}); end
    step(0, 8'h00, 0, 1);
    nvec++; if (st !== {16'h1111, 4'b0000}) begin nerr++; $display("FAIL ovf_clear got %h exp %h", st, {16'h1111, 4'b0000}); end
  endtask
  task automatic test_back_to_back();
    step(1, 8'hEF, 0, 0);
    step(1, 8'hBE, 0, 0);
    nvec++; if (st !== {16'hBEEF, 4'b1000}) begin nerr++; $display("FAIL b2b_first got %h exp %h", st, {16'hBEEF, 4'b1000}); end
    step(1, 8'hFE, 0, 0);
    step(1, 8'hCA, 1, 0);
    nvec++; if (st !== {16'hCAFE, 4'b1000}) begin nerr++; $display("FAIL b2b_swap got %h exp %h", st, {16'hCAFE, 4'b1000}); end
    step(0, 8'h00, 1, 0);
    nvec++; if (st !== {16'hCAFE, 4'b0000}) begin nerr++; $display("FAIL b2b_drain got %h exp %h", st, {16'hCAFE, 4'b0000}); end
  endtask
  task automatic test_reset_mid();
    step(1, 8'h55, 0, 0);
    rst = 1'b0;
    #1;
    nvec++; if (st !== 20'h0) begin nerr++; $display("FAIL rstmid_async got %h exp %h", st, 20'h0); end
    model_reset();
    @(negedge clk) rst = 1'b1;
    step(1, 8'h66, 0, 0);
    nvec++; if (st !== {16'h0000, 4'b0100}) begin nerr++; $display("FAIL rstmid_lo got %h exp %h", st, {16'h0000, 4'b0100}); end
    step(1, 8'h77, 0, 0);
    for (int i = 0; i < T + 4; i++) begin
      nvec++; if (st !== {16'h7766, 4'b1000}) begin nerr++; $display("FAIL rstmid_hold%0d got %h exp %h", i, st, {16'h7766, 4'b1000}); end
      step(0, 8'h00, 0, 0);
    end
    step(0, 8'h00, 1, 0);
  endtask
  task automatic test_expiry_tie();
    step(1, 8'hAB, 1, 0);
    for (int i = 0; i < T - 1; i++) step(0, 8'h00, 1, 0);
    step(1, 8'hCD, 1, 0);
    nvec++; if (st !== {16'hCDAB, 4'b1000}) begin nerr++; $display("FAIL tie_word got %h exp %h", st, {16'hCDAB, 4'b1000}); end
    step(0, 8'h00, 1, 0);
    nvec++; if (st !== {16'hCDAB, 4'b0000}) begin nerr++; $display("FAIL tie_after got %h exp %h", st, {16'hCDAB, 4'b0000}); end
    step(1, 8'h5A, 1, 1);
    nvec++; if (st !== {16'hCDAB, 4'b0000}) begin nerr++; $display("FAIL clear_ignores_byte got %h exp %h", st, {16'hCDAB, 4'b0000}); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      int rate;
      rate = ((i / 250) % 2 == 1) ? 45 : 4;
      step($urandom_range(0, 99) < rate, 8'($urandom), ((i / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1), $urandom_range(0, 99) == 0);
      nvec++;
      if (st !== {m_word, m_wv, m_have_lo, m_ferr, m_ovf}) begin
        nerr++; $display("FAIL random cyc %0d got %h exp %h", i, st, {m_word, m_wv, m_have_lo, m_ferr, m_ovf});
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_expiry_tie();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_rx_pack16.md
UART_RX_PACK16 -- requirements
Module: uart_rx_pack16

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000: maximum idle clocks allowed between low and high byte.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port clear, input, 1: synchronous flush of all state.
REQ-005 SHALL have port byte_valid, input, 1: one-cycle strobe from the UART receiver, byte_in valid.
REQ-006 SHALL have port byte_in, input, 8: received byte.
REQ-007 SHALL have port word_ready, input, 1: consumer accepts word_out.
REQ-008 SHALL have port word_out, output, 16: assembled word.
REQ-009 SHALL have port word_valid, output, 1: word_out holds an unconsumed word.
REQ-010 SHALL have port busy, output, 1: low byte held, high byte pending.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse on timeout discard.
REQ-012 SHALL have port overflow, output, 1: sticky, a completed word was dropped.

Function
REQ-013 SHALL assemble little-endian: first byte -> word[7:0], second byte -> word[15:8], matching the 16-bit-to-byte transmitter's low-byte-first order.
REQ-014 SHALL use assembler FSM states S_LO (waiting for low byte) and S_HI (low byte held, waiting for high byte).
REQ-015 S_LO with byte_valid SHALL store byte_in as the low byte, clear the timeout counter, and go to S_HI.
REQ-016 S_HI with byte_valid SHALL complete the word and go to S_LO; word_valid SHALL rise on the next clock edge (1-cycle latency from the high-byte strobe).
REQ-017 busy SHALL equal (state == S_HI).
REQ-018 In S_HI without byte_valid, the 16-bit timeout counter SHALL increment; when the counter reaches TIMEOUT_CYCLES-1, the block SHALL discard the low byte, return to S_LO, and pulse frame_err for exactly one cycle.
REQ-019 byte_valid in the expiry cycle SHALL win: the word completes normally and frame_err stays low.
REQ-020 The output register SHALL be one word deep; word_out and word_valid SHALL hold until a rising edge with word_valid && word_ready.
REQ-021 Completion when word_valid=1 and word_ready=0 SHALL drop the new word, leave word_out unchanged, and set overflow.
REQ-022 Completion when word_valid=1 and word_ready=1 in the same cycle SHALL accept the old word, load the new word, and keep word_valid high with no overflow.
REQ-023 word_ready while word_valid=0 SHALL have no effect.
REQ-024 clear SHALL take priority over all other inputs: return to S_LO, zero the counter, clear word_valid and overflow, and suppress frame_err; byte_valid in that same cycle SHALL be ignored.
REQ-025 word_out SHALL retain its last value after consumption; only word_valid qualifies it.

Reset
REQ-026 When rst=0, the block SHALL asynchronously force: state S_LO, counter 0, low-byte register 0, word_out 16'h0000, word_valid 0, busy 0, frame_err 0, overflow 0.
REQ-027 Reset during S_HI or with a pending word SHALL discard all data, with no frame_err or overflow on release.
REQ-028 The first byte_valid sampled on the first clock edge after reset release SHALL be accepted.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (S_LO, S_HI) and the default timeout constant, both also used by the transmitter-side block.
REQ-030 The design SHALL be a single module with no sub-modules; the output register and timeout counter SHALL be inline.

Verification
REQ-031 Bytes 8'h34 then 8'h12, 3 cycles apart, consumer ready -> word_out 16'h1234, word_valid high 1 cycle after the second strobe, busy high in between.
REQ-032 Byte 8'hAA then no byte for TIMEOUT_CYCLES (bench sets 16) -> frame_err pulses once at 16 cycles, busy falls; then 8'h01, 8'h02 -> 16'h0201.
REQ-033 word_ready=0; send 16'h1111 then 16'h2222 as byte pairs -> word_out stays 16'h1111 and overflow=1; assert clear -> word_valid=0 and overflow=0.
REQ-034 Pending word 16'hBEEF; complete 16'hCAFE in the same cycle word_ready=1 -> word_out 16'hCAFE, word_valid stays 1, overflow 0.
REQ-035 Drive rst low after the low byte 8'h55, release, then send 8'h66, 8'h77 -> word_out 16'h7766, no frame_err.
REQ-036 High byte arrives exactly in the timeout-expiry cycle -> word completes and frame_err stays 0.
